shft_seq: RTL
=============

SHFT_SEQ -- requirements
Module: shft_seq

Interface
REQ-001 The block SHALL have parameter N, default 7, meaning MSB index of the shifter data word (word width N+1).
REQ-002 The block SHALL have parameter CW, default 4, meaning width of the shift-count bus (holds 0..N+1).
REQ-003 The block SHALL have parameter DEB_CYCLES, default 500000, meaning consecutive equal samples required to accept a button level.
REQ-004 The block SHALL have parameter STEP_DIV, default 50000000, meaning clock cycles per shift-count increment.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-007 The block SHALL have port btn, input, 1 bit, meaning the raw asynchronous start pushbutton (active-high).
REQ-008 The block SHALL have port dir_sw, input, 1 bit, meaning requested direction (0 = right/toward bit 0, 1 = left).
REQ-009 The block SHALL have port cnt_sw, input, CW bits, meaning the requested total shift count.
REQ-010 The block SHALL have port strt, output, 1 bit, meaning a one-cycle pulse on sequence start to the downstream shifter.
REQ-011 The block SHALL have port shftdir, output, 1 bit, meaning the latched direction driven to the shifter.
REQ-012 The block SHALL have port noofshfts, output, CW bits, meaning the current shift count driven to the shifter.
REQ-013 The block SHALL have port busy, output, 1 bit, meaning high while a sequence is in progress.
REQ-014 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse on sequence completion.

Function
REQ-015 btn SHALL pass through a 2-flop synchronizer, then a debouncer that updates its level only after DEB_CYCLES consecutive identical synchronized samples.
REQ-016 A press SHALL be the 0->1 transition of the debounced level; exactly one press event per transition.
REQ-017 The FSM SHALL have states IDLE, RUN, DONE.
REQ-018 IDLE, on press: latch shftdir<=dir_sw, target<=min(cnt_sw, N+1), noofshfts<=0, pulse strt for one cycle; go to RUN if target>0, else DONE.
REQ-019 RUN: a step timer SHALL load STEP_DIV-1 on entry and decrement each cycle; at 0 it increments noofshfts and reloads; when the incremented value equals target, the next state is DONE.
REQ-020 DONE entry SHALL occur exactly target*STEP_DIV cycles after RUN entry.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-023 shftdir and noofshfts SHALL hold their final values in IDLE until the next press.
REQ-024 Presses and dir_sw/cnt_sw changes during RUN or DONE SHALL be ignored; no queuing.
REQ-025 cnt_sw values above N+1 SHALL clamp to N+1; noofshfts SHALL never exceed N+1.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, strt=0, done=0, busy=0, shftdir=0, noofshfts=0, step timer=0, synchronizer and debounced level=0, debounce counter=0.
REQ-027 rst asserted mid-sequence SHALL abort it with no done pulse; a button held through reset release SHALL NOT produce a press until released and pressed again.

Structure
REQ-028 Package shft_pkg SHALL hold N, CW, and the FSM state enum (IDLE, RUN, DONE), shared with the shifter.
REQ-029 Sub-module btn_debounce (synchronizer + debouncer + rising-edge pulse, parameter DEB_CYCLES) SHALL be instantiated once.

Verification (bench overrides: DEB_CYCLES=2, STEP_DIV=4)
REQ-030 dir_sw=1, cnt_sw=3, clean press -> one strt pulse; noofshfts 0,1,2,3 at 4-cycle spacing; done pulses 12 cycles after RUN entry; shftdir=1 held afterwards.
REQ-031 cnt_sw=0, press -> strt then done on the next cycle; noofshfts stays 0; busy high for exactly one cycle.
REQ-032 cnt_sw=15 -> counts to 8 and stops; done 32 cycles after RUN entry.
REQ-033 btn glitch of 1 cycle -> no strt; held 4+ cycles -> exactly one strt; second press during RUN and dir_sw toggle mid-RUN -> no effect.
REQ-034 rst at noofshfts=2 during RUN -> all outputs 0 next cycle, no done; btn held through reset -> no press until re-pressed.

Source files
------------

// File: rtl/shft_pkg.sv
// Shared definitions for the shift sequencer and the downstream shifter:
// data-word geometry and the sequencer state encoding.
package shft_pkg;

  localparam int SHFT_N  = 7;
  localparam int SHFT_CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, level debouncer, and a single-cycle
// pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNTW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEB_CYCLES - 1);

  logic [1:0]      sync;
  logic [1:0]      fill;
  logic            level;
  logic            armed;
  logic            eff;
  logic [CNTW-1:0] cnt;

  // Until a stable release has been seen, treat the button as held so that a
  // press held through reset cannot fire; fill masks the reset-flushed sync.
  assign eff = level | ~armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      fill  <= '0;
      level <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      fill  <= {fill[0], 1'b1};
      press <= 1'b0;
      if (fill[1]) begin
        if (sync[1] == eff) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt <= '0;
          if (!armed) begin
            armed <= 1'b1;
          end else begin
            level <= sync[1];
            press <= sync[1];
          end
        end else begin
          cnt <= cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/shft_seq.sv
// Shift sequencer: on a debounced button press, latches direction and a clamped
// shift count, then steps noofshfts up once every STEP_DIV cycles until done.
module shft_seq
  import shft_pkg::*;
#(
  parameter int N          = SHFT_N,
  parameter int CW         = SHFT_CW,
  parameter int DEB_CYCLES = 500000,
  parameter int STEP_DIV   = 50000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn,
  input  logic          dir_sw,
  input  logic [CW-1:0] cnt_sw,
  output logic          strt,
  output logic          shftdir,
  output logic [CW-1:0] noofshfts,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0] TLOAD  = TW'(STEP_DIV - 1);
  localparam logic [CW-1:0] MAXCNT = CW'(N + 1);

  logic [1:0]    state;
  logic [CW-1:0] target;
  logic [CW-1:0] clamped;
  logic [CW-1:0] nxtcnt;
  logic [TW-1:0] timer;
  logic          press;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press)
  );

  assign clamped = (cnt_sw > MAXCNT) ? MAXCNT : cnt_sw;
  assign nxtcnt  = noofshfts + CW'(1);
  assign strt    = (state == IDLE) && press;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // A zero target skips RUN entirely so done follows strt by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shftdir   <= 1'b0;
      noofshfts <= '0;
      target    <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            shftdir   <= dir_sw;
            target    <= clamped;
            noofshfts <= '0;
            timer     <= TLOAD;
            state     <= (clamped == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (timer == '0) begin
            timer     <= TLOAD;
            noofshfts <= nxtcnt;
            if (nxtcnt == target) state <= DONE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
